// File: rtl/regfile_reader.sv
// regfile_reader
//    Read-side controller for the register bank. Samples the flattened register
//    outputs and returns them over a valid/ready handshake, either as a single
//    addressed read or as a sequential scan of every register.
//
// Ports
//    clk          rising-edge clock
//    reset_n      asynchronous active-low reset
//    reg_bus      flattened register outputs, register i at [i*WIDTH +: WIDTH]
//    rd_addr      address for a single read
//    rd_req       single-read request, sampled in IDLE only
//    scan_start   full-scan request, sampled in IDLE only (wins over rd_req)
//    rd_ready     consumer accepts rd_data this cycle
//    rd_data      registered read data
//    rd_addr_out  address rd_data came from
//    rd_valid     rd_data/rd_addr_out valid
//    busy         high whenever not in IDLE
//    scan_done    one-cycle pulse after the last scan beat is accepted
//
// state  | meaning
// IDLE   | waiting for scan_start or rd_req
// SINGLE | one addressed beat presented, held until accepted
// SCAN   | presenting beat ptr of a full scan, advances on each handshake

module regfile_reader #(
   parameter int NREGS = 8,
   parameter int WIDTH = 4,
   parameter int AW    = 3
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NREGS*WIDTH-1:0] reg_bus,
   input  logic [AW-1:0]          rd_addr,
   input  logic                   rd_req,
   input  logic                   scan_start,
   input  logic                   rd_ready,
   output logic [WIDTH-1:0]       rd_data,
   output logic [AW-1:0]          rd_addr_out,
   output logic                   rd_valid,
   output logic                   busy,
   output logic                   scan_done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SINGLE = 2'd1,
      SCAN   = 2'd2
   } state_t;

   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   state_t           state, state_nxt;
   logic [AW-1:0]    ptr, ptr_nxt;
   logic [WIDTH-1:0] data_nxt;
   logic [AW-1:0]    addr_nxt;
   logic             valid_nxt;
   logic             done_nxt;
   logic             busy_nxt;
   logic             hs;

   logic [AW-1:0]    sel_addr;
   logic [WIDTH-1:0] sel_data;

   assign hs = rd_valid & rd_ready;

   // One read mux shared by every load: the address it looks at depends on
   // which beat is about to be loaded.
   always_comb begin
      sel_addr = rd_addr;
      case (state)
         IDLE:    sel_addr = scan_start ? '0 : rd_addr;
         SCAN:    sel_addr = AW'(ptr + 1'b1);
         default: sel_addr = rd_addr;
      endcase
   end

   // Addresses past the last register read back as zero.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (sel_addr == AW'(i)) sel_data = reg_bus[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      data_nxt  = rd_data;
      addr_nxt  = rd_addr_out;
      valid_nxt = rd_valid;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (scan_start) begin
               data_nxt  = sel_data;
               addr_nxt  = '0;
               valid_nxt = 1'b1;
               ptr_nxt   = '0;
               state_nxt = SCAN;
            end else if (rd_req) begin
               data_nxt  = sel_data;
               addr_nxt  = rd_addr;
               valid_nxt = 1'b1;
               state_nxt = SINGLE;
            end
         end
         SINGLE: begin
            if (hs) begin
               valid_nxt = 1'b0;
               state_nxt = IDLE;
            end
         end
         SCAN: begin
            if (hs) begin
               if (ptr == LAST) begin
                  valid_nxt = 1'b0;
                  done_nxt  = 1'b1;
                  ptr_nxt   = '0;
                  state_nxt = IDLE;
               end else begin
                  ptr_nxt  = AW'(ptr + 1'b1);
                  data_nxt = sel_data;
                  addr_nxt = AW'(ptr + 1'b1);
               end
            end
         end
         default: begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         ptr         <= '0;
         rd_data     <= '0;
         rd_addr_out <= '0;
         rd_valid    <= 1'b0;
         busy        <= 1'b0;
         scan_done   <= 1'b0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         rd_data     <= data_nxt;
         rd_addr_out <= addr_nxt;
         rd_valid    <= valid_nxt;
         busy        <= busy_nxt;
         scan_done   <= done_nxt;
      end
   end

endmodule
